// File: rtl/clk_lock_supervisor.sv
// Per-channel clock generator reset sequencer and LOCKED qualifier with ready/fault reporting.
// Build option: define CLKSUP_AUTORETRY_EN for bounded automatic re-reset on lock loss or timeout.
module clk_lock_supervisor #(
  parameter int N_CH          = 2,
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_W         = 20,
  parameter int RETRY_W       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         locked_in,
  input  logic [N_CH-1:0]         restart,
  output logic [N_CH-1:0]         mmcm_rst,
  output logic [N_CH-1:0]         ready,
  output logic                    all_ready,
  output logic [N_CH-1:0]         fault,
  output logic [N_CH*RETRY_W-1:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_RESET_PULSE,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_READY,
    ST_FAULT
  } state_t;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

`ifdef CLKSUP_AUTORETRY_EN
  localparam bit AUTO_RETRY = 1'b1;
`else
  localparam bit AUTO_RETRY = 1'b0;
`endif

  logic all_ready_q, all_ready_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [1:0]         sync_q, sync_d;
    logic               locked_s;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               mmcm_rst_q, mmcm_rst_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic               take_failure;

    assign locked_s = sync_q[1];

    always_comb begin
      sync_d       = {sync_q[0], locked_in[g]};
      state_d      = state_q;
      timer_d      = timer_q;
      retry_d      = retry_q;
      take_failure = 1'b0;

      case (state_q)
        ST_RESET_PULSE: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            timer_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            take_failure = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        // A dropout always wins over the window completing in the same cycle.
        ST_STABLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_READY;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_READY: begin
          if (!locked_s) begin
            take_failure = 1'b1;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET_PULSE;
          timer_d = '0;
        end
      endcase

      // The retry count only advances below its limit, so it can never wrap.
      if (take_failure) begin
        timer_d = '0;
        if (!AUTO_RETRY || (retry_q >= RETRY_MAX)) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_RESET_PULSE;
          retry_d = retry_q + 1'b1;
        end
      end

      if (restart[g]) begin
        state_d = ST_RESET_PULSE;
        timer_d = '0;
        retry_d = '0;
      end

      mmcm_rst_d = (state_d == ST_RESET_PULSE);
      ready_d    = (state_d == ST_READY);
      fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q     <= '0;
        state_q    <= ST_RESET_PULSE;
        timer_q    <= '0;
        retry_q    <= '0;
        mmcm_rst_q <= 1'b1;
        ready_q    <= 1'b0;
        fault_q    <= 1'b0;
      end else begin
        sync_q     <= sync_d;
        state_q    <= state_d;
        timer_q    <= timer_d;
        retry_q    <= retry_d;
        mmcm_rst_q <= mmcm_rst_d;
        ready_q    <= ready_d;
        fault_q    <= fault_d;
      end
    end

    assign mmcm_rst[g]                      = mmcm_rst_q;
    assign ready[g]                         = ready_q;
    assign fault[g]                         = fault_q;
    assign retry_cnt[g*RETRY_W +: RETRY_W]  = retry_q;
  end

  always_comb begin
    all_ready_d = &ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      all_ready_q <= 1'b0;
    end else begin
      all_ready_q <= all_ready_d;
    end
  end

  assign all_ready = all_ready_q;

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Self-checking bench for clk_lock_supervisor with a short-timer configuration.
// Expectations follow CLKSUP_AUTORETRY_EN when it is defined for the whole build.
module tb_clk_lock_supervisor;

  localparam int N_CH    = 2;
  localparam int RETRY_W = 4;

  logic                    clk;
  logic                    reset;
  logic [N_CH-1:0]         locked_in;
  logic [N_CH-1:0]         restart;
  logic [N_CH-1:0]         mmcm_rst;
  logic [N_CH-1:0]         ready;
  logic                    all_ready;
  logic [N_CH-1:0]         fault;
  logic [N_CH*RETRY_W-1:0] retry_cnt;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [1:0] lock;
    logic [1:0] rst_exp;
    logic [1:0] rdy_exp;
    logic [1:0] flt_exp;
    logic       all_exp;
  } vec_t;

  vec_t vecs[18];
  vec_t sb[$];

  clk_lock_supervisor #(
    .N_CH(N_CH), .RST_CYCLES(4), .STABLE_CYCLES(8), .LOCK_TIMEOUT(32),
    .MAX_RETRIES(2), .CNT_W(8), .RETRY_W(RETRY_W)
  ) dut (
    .clk(clk), .reset(reset), .locked_in(locked_in), .restart(restart),
    .mmcm_rst(mmcm_rst), .ready(ready), .all_ready(all_ready),
    .fault(fault), .retry_cnt(retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [RETRY_W-1:0] retryOf(input int ch);
    return retry_cnt[ch*RETRY_W +: RETRY_W];
  endfunction

  function automatic logic getSig(input int which, input int ch);
    case (which)
      0:       return ready[ch];
      1:       return mmcm_rst[ch];
      2:       return fault[ch];
      default: return all_ready;
    endcase
  endfunction

  // Edges until the selected output reaches val; -1 when the budget runs out.
  task automatic waitSig(input int which, input int ch, input logic val, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (getSig(which, ch) === val) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    locked_in = v.lock;
    sb.push_back(v);
    step();
  endtask

  task automatic checkOutput(input int row);
    vec_t e;
    e = sb.pop_front();
    checkValue($sformatf("row%0d mmcm_rst", row), 32'(mmcm_rst), 32'(e.rst_exp));
    checkValue($sformatf("row%0d ready", row), 32'(ready), 32'(e.rdy_exp));
    checkValue($sformatf("row%0d fault", row), 32'(fault), 32'(e.flt_exp));
    checkValue($sformatf("row%0d all_ready", row), 32'(all_ready), 32'(e.all_exp));
  endtask

  initial begin
    int  n;
    int  pulses;
    int  cur_len;
    int  bad_len;
    int  fault_edge;
    int  rst_after_fault;
    int  ch0_dropped;
    logic prev;
    logic seen_high;

    reset     = 1'b1;
    locked_in = '0;
    restart   = '0;

    // Power-up table: edge e after reset release; lock 0 raised before edge 7.
    for (int i = 0; i < 18; i++) begin
      vecs[i].lock    = (i + 1 >= 7)  ? 2'b01 : 2'b00;
      vecs[i].rst_exp = (i + 1 <= 3)  ? 2'b11 : 2'b00;
      vecs[i].rdy_exp = (i + 1 >= 17) ? 2'b01 : 2'b00;
      vecs[i].flt_exp = 2'b00;
      vecs[i].all_exp = 1'b0;
    end

    repeat (3) step();
    checkValue("reset mmcm_rst", 32'(mmcm_rst), 32'h3);
    checkValue("reset ready", 32'(ready), 32'h0);
    checkValue("reset all_ready", 32'(all_ready), 32'h0);
    checkValue("reset fault", 32'(fault), 32'h0);
    checkValue("reset retry_cnt", 32'(retry_cnt), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i + 1);
    end

    // Channel 1 locks late; all_ready follows its ready by one edge.
    locked_in = 2'b11;
    waitSig(0, 1, 1'b1, 40, n);
    checkValue("ch1 ready latency", 32'(n), 32'd11);
    checkValue("all_ready before lag", 32'(all_ready), 32'h0);
    step();
    checkValue("all_ready after lag", 32'(all_ready), 32'h1);

    // Lock loss on channel 0 while ready.
    locked_in = 2'b10;
    waitSig(0, 0, 1'b0, 20, n);
    checkValue("lockloss ready fall", 32'(n), 32'd3);
    checkValue("lockloss ch1 ready", 32'(ready[1]), 32'h1);
`ifdef CLKSUP_AUTORETRY_EN
    checkValue("lockloss mmcm_rst rise", 32'(mmcm_rst[0]), 32'h1);
    checkValue("lockloss fault", 32'(fault[0]), 32'h0);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (mmcm_rst[0]) n++;
      else break;
    end
    checkValue("lockloss pulse length", 32'(n), 32'd4);
    checkValue("lockloss retry", 32'(retryOf(0)), 32'd1);
`else
    checkValue("lockloss mmcm_rst stays low", 32'(mmcm_rst[0]), 32'h0);
    checkValue("lockloss fault", 32'(fault[0]), 32'h1);
    checkValue("lockloss retry", 32'(retryOf(0)), 32'd0);
    seen_high = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (mmcm_rst[0] || !fault[0]) seen_high = 1'b1;
    end
    checkValue("fault holds without restart", 32'(seen_high), 32'h0);
`endif
    checkValue("lockloss ch1 still ready", 32'(ready[1]), 32'h1);

    restart = 2'b01;
    step();
    restart = 2'b00;
    checkValue("restart0 mmcm_rst", 32'(mmcm_rst[0]), 32'h1);
    checkValue("restart0 fault", 32'(fault[0]), 32'h0);
    checkValue("restart0 retry", 32'(retryOf(0)), 32'd0);

    // Stability window: drop lock for 3 cycles once the STABLE count is 5.
    repeat (8) step();
    locked_in = 2'b11;
    repeat (8) step();
    locked_in = 2'b10;
    seen_high = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (ready[0]) seen_high = 1'b1;
    end
    checkValue("window dropout ready", 32'(seen_high), 32'h0);
    locked_in = 2'b11;
    waitSig(0, 0, 1'b1, 40, n);
    checkValue("window relock latency", 32'(n), 32'd11);

    // Channel 1 held unlocked after restart: timeouts, retries, fault.
    locked_in = 2'b01;
    restart   = 2'b10;
    step();
    restart   = 2'b00;
    checkValue("timeout first mmcm_rst", 32'(mmcm_rst[1]), 32'h1);
    pulses = 1; cur_len = 1; bad_len = 0; fault_edge = -1;
    rst_after_fault = 0; ch0_dropped = 0; prev = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      step();
      if (mmcm_rst[1] && !prev) begin
        pulses++;
        cur_len = 0;
      end
      if (mmcm_rst[1]) cur_len++;
      if (!mmcm_rst[1] && prev && cur_len != 4) bad_len++;
      if (fault[1] && fault_edge < 0) fault_edge = k;
      if (fault_edge >= 0 && mmcm_rst[1]) rst_after_fault++;
      if (!ready[0]) ch0_dropped++;
      prev = mmcm_rst[1];
    end
    checkValue("timeout bad pulse lengths", 32'(bad_len), 32'd0);
    checkValue("timeout mmcm_rst after fault", 32'(rst_after_fault), 32'd0);
    checkValue("timeout ch0 unaffected", 32'(ch0_dropped), 32'd0);
    checkValue("timeout fault now", 32'(fault[1]), 32'h1);
`ifdef CLKSUP_AUTORETRY_EN
    checkValue("timeout pulse count", 32'(pulses), 32'd3);
    checkValue("timeout fault edge", 32'(fault_edge), 32'd108);
    checkValue("timeout retry", 32'(retryOf(1)), 32'd2);
`else
    checkValue("timeout pulse count", 32'(pulses), 32'd1);
    checkValue("timeout fault edge", 32'(fault_edge), 32'd36);
    checkValue("timeout retry", 32'(retryOf(1)), 32'd0);
`endif

    // Restart out of FAULT.
    restart = 2'b10;
    step();
    restart = 2'b00;
    checkValue("fault restart mmcm_rst", 32'(mmcm_rst[1]), 32'h1);
    checkValue("fault restart fault", 32'(fault[1]), 32'h0);
    checkValue("fault restart retry", 32'(retryOf(1)), 32'd0);

    // Restart coincident with the timeout edge (36 edges after restart).
    repeat (35) step();
    checkValue("pre-timeout mmcm_rst", 32'(mmcm_rst[1]), 32'h0);
    restart = 2'b10;
    step();
    restart = 2'b00;
    checkValue("restart vs timeout mmcm_rst", 32'(mmcm_rst[1]), 32'h1);
    checkValue("restart vs timeout fault", 32'(fault[1]), 32'h0);
    checkValue("restart vs timeout retry", 32'(retryOf(1)), 32'd0);

    // Restart mid-pulse restarts the full pulse count.
    repeat (2) step();
    restart = 2'b10;
    step();
    restart = 2'b00;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (mmcm_rst[1]) n++;
      else break;
    end
    checkValue("mid-pulse restart length", 32'(n), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
